// File: rtl/rv32i_types.sv
// Shared core types; the cache arbiter adds its FSM state and request-source enums.
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        ARB_SRC_I,
        ARB_SRC_D
    } arb_src_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and memory line-port signals seen by cache_arbiter.
interface cache_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_address;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    // Arbiter view.
    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_address, m_wdata
    );

    // Caches-plus-memory view.
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_address, m_wdata
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select; ARB_ROUND_ROBIN_EN enables tie-breaking on the last-served source.
module arb_pick
    import rv32i_types::*;
(
    input  logic     i_req_i,
    input  logic     d_req_i,
    input  arb_src_t last_i,
    output logic     any_o,
    output arb_src_t win_o
);

    assign any_o = i_req_i | d_req_i;

    always_comb begin
        win_o = ARB_SRC_D;
        if (i_req_i && !d_req_i) begin
            win_o = ARB_SRC_I;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (i_req_i && d_req_i && (last_i == ARB_SRC_D)) begin
            win_o = ARB_SRC_I;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    arb_src_t unused_last;
    assign unused_last = last_i;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Serialises icache/dcache line misses onto one memory port. Optional macro: ARB_ROUND_ROBIN_EN.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    arb_src_t          owner_q, owner_d;
    arb_src_t          last_src, win;
    logic              req_any;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              fire, i_hit, d_hit;

    arb_pick u_pick (
        .i_req_i (bus.i_read),
        .d_req_i (bus.d_read | bus.d_write),
        .last_i  (last_src),
        .any_o   (req_any),
        .win_o   (win)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_src_t last_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ARB_SRC_D;
        end else if ((state_q == ARB_IDLE) && req_any) begin
            last_q <= win;
        end
    end
    assign last_src = last_q;
`else
    assign last_src = ARB_SRC_D;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    state_d = ARB_BUSY;
                    owner_d = win;
                    if (win == ARB_SRC_D) begin
                        // A write wins over an (illegal) simultaneous read.
                        wr_d    = bus.d_write;
                        rd_d    = !bus.d_write;
                        addr_d  = bus.d_address;
                        wdata_d = bus.d_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                        addr_d  = bus.i_address;
                        wdata_d = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (bus.m_resp) begin
                    state_d = ARB_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default: begin
                state_d = ARB_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_SRC_D;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign fire  = rst_n && (state_q == ARB_BUSY) && bus.m_resp;
    assign i_hit = fire && (owner_q == ARB_SRC_I);
    assign d_hit = fire && (owner_q == ARB_SRC_D);

    assign bus.i_resp    = i_hit;
    assign bus.d_resp    = d_hit;
    assign bus.i_rdata   = i_hit ? bus.m_rdata : '0;
    assign bus.d_rdata   = d_hit ? bus.m_rdata : '0;
    assign bus.m_read    = rd_q;
    assign bus.m_write   = wr_q;
    assign bus.m_address = addr_q;
    assign bus.m_wdata   = wdata_q;

`ifndef SYNTHESIS
    a_no_dual_d: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.d_read && bus.d_write))
        else $error("cache_arbiter: d_read and d_write both high");
    a_resp_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
        bus.m_resp |-> (state_q == ARB_BUSY))
        else $error("cache_arbiter: m_resp outside BUSY");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter with a transaction-level reference model.
module tb_cache_arbiter;
    import rv32i_types::*;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: one outstanding transaction, then a cooldown before the next grant.
    logic          mdl_act, mdl_wr, mdl_src_d, mdl_last_d;
    int            mdl_cool;
    logic [AW-1:0] mdl_addr;
    logic [LW-1:0] mdl_data;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic d_wins(input logic ir, input logic dr, input logic last_d);
        if (!ir) return 1'b1;
        if (!dr) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return last_d | 1'b1;
`endif
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < int'(LW / 32); k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_act    <= 1'b0;
            mdl_wr     <= 1'b0;
            mdl_src_d  <= 1'b1;
            mdl_last_d <= 1'b1;
            mdl_cool   <= 0;
            mdl_addr   <= '0;
            mdl_data   <= '0;
        end else if (mdl_act) begin
            if (bus.m_resp) begin
                mdl_act  <= 1'b0;
                mdl_cool <= 1;
            end
        end else if (mdl_cool > 0) begin
            mdl_cool <= mdl_cool - 1;
        end else if (bus.i_read || bus.d_read || bus.d_write) begin
            mdl_act    <= 1'b1;
            mdl_src_d  <= d_wins(bus.i_read, bus.d_read | bus.d_write, mdl_last_d);
            mdl_last_d <= d_wins(bus.i_read, bus.d_read | bus.d_write, mdl_last_d);
            mdl_wr     <= d_wins(bus.i_read, bus.d_read | bus.d_write, mdl_last_d) && bus.d_write;
            mdl_addr   <= d_wins(bus.i_read, bus.d_read | bus.d_write, mdl_last_d) ?
                          bus.d_address : bus.i_address;
            mdl_data   <= bus.d_wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_read", bus.m_read, mdl_act && !mdl_wr);
            chk("m_write", bus.m_write, mdl_act && mdl_wr);
            chk("m_address", bus.m_address, mdl_addr);
            if (mdl_act && mdl_wr) chk("m_wdata", bus.m_wdata, mdl_data);
            chk("i_resp", bus.i_resp, rst_n && mdl_act && !mdl_src_d && bus.m_resp);
            chk("d_resp", bus.d_resp, rst_n && mdl_act && mdl_src_d && bus.m_resp);
            chk("i_rdata", bus.i_rdata,
                (rst_n && mdl_act && !mdl_src_d && bus.m_resp) ? bus.m_rdata : '0);
            chk("d_rdata", bus.d_rdata,
                (rst_n && mdl_act && mdl_src_d && bus.m_resp) ? bus.m_rdata : '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in a cycle where a grant must be visible; answers it and checks routing.
    task automatic answer(input string nm, input bit wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wd, input bit to_d, input logic [LW-1:0] rd);
        chk({nm, "_mrd"}, bus.m_read, !wr);
        chk({nm, "_mwr"}, bus.m_write, wr);
        chk({nm, "_addr"}, bus.m_address, addr);
        if (wr) chk({nm, "_wdata"}, bus.m_wdata, wd);
        bus.m_resp  = 1'b1;
        bus.m_rdata = rd;
        #1;
        chk({nm, "_iresp"}, bus.i_resp, !to_d);
        chk({nm, "_dresp"}, bus.d_resp, to_d);
        chk({nm, "_irdata"}, bus.i_rdata, to_d ? '0 : rd);
        chk({nm, "_drdata"}, bus.d_rdata, to_d ? rd : '0);
    endtask

    logic [LW-1:0] aa_line, ff55_line;
    logic          i_got, d_got;
    int            mem_wait, n_i_served, n_d_served;

    initial begin
        aa_line   = {(LW / 8){8'hAA}};
        ff55_line = {(LW / 8){8'h55}};
        bus.i_read = 1'b1;  bus.i_address = 32'h40;
        bus.d_read = 1'b0;  bus.d_write = 1'b0;
        bus.d_address = '0; bus.d_wdata = '0;
        bus.m_resp = 1'b0;  bus.m_rdata = '0;

        // Reset with a pending i_read.
        step();
        chk_en = 1'b1;
        step();
        chk("rst_mread", bus.m_read, 1'b0);
        chk("rst_mwrite", bus.m_write, 1'b0);
        chk("rst_maddr", bus.m_address, '0);
        chk("rst_iresp", bus.i_resp, 1'b0);
        chk("rst_dresp", bus.d_resp, 1'b0);

        // Lone icache read, memory answers in cycle 3.
        rst_n = 1'b1;
        step();
        chk("lone_c1_mrd", bus.m_read, 1'b1);
        chk("lone_c1_addr", bus.m_address, 32'h40);
        chk("lone_c1_iresp", bus.i_resp, 1'b0);
        step();
        chk("lone_c2_mrd", bus.m_read, 1'b1);
        step();
        answer("lone", 1'b0, 32'h40, '0, 1'b0, aa_line);
        step();
        bus.m_resp = 1'b0; bus.i_read = 1'b0;
        chk("lone_c4_mrd", bus.m_read, 1'b0);
        chk("lone_c4_iresp", bus.i_resp, 1'b0);
        step();

        // Simultaneous i_read and d_write from a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.i_read = 1'b1; bus.i_address = 32'h100;
        bus.d_write = 1'b1; bus.d_address = 32'h200; bus.d_wdata = ff55_line;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        answer("rr_first_i", 1'b0, 32'h100, '0, 1'b0, rand_line());
        step();
        bus.m_resp = 1'b0; bus.i_read = 1'b0;
        chk("rr_dead_mwr", bus.m_write, 1'b0);
        step();
        bus.i_read = 1'b1;
        step();
        answer("rr_tie2_d", 1'b1, 32'h200, ff55_line, 1'b1, rand_line());
        step();
        bus.m_resp = 1'b0; bus.d_write = 1'b0;
        step();
        step();
        answer("rr_then_i", 1'b0, 32'h100, '0, 1'b0, rand_line());
        step();
        bus.m_resp = 1'b0; bus.i_read = 1'b0;
        step();
`else
        answer("tie_d", 1'b1, 32'h200, ff55_line, 1'b1, rand_line());
        step();
        bus.m_resp = 1'b0; bus.d_write = 1'b0;
        chk("tie_dead_mrd", bus.m_read, 1'b0);
        chk("tie_dead_mwr", bus.m_write, 1'b0);
        step();
        chk("tie_idle_mrd", bus.m_read, 1'b0);
        step();
        answer("tie_i", 1'b0, 32'h100, '0, 1'b0, rand_line());
        step();
        bus.m_resp = 1'b0; bus.i_read = 1'b0;
        step();
`endif

        // Reset while BUSY; m_resp during reset must not be routed.
        bus.d_read = 1'b1; bus.d_address = 32'h300;
        step();
        chk("rb_busy_mrd", bus.m_read, 1'b1);
        rst_n = 1'b0;
        step();
        chk("rb_mrd_dropped", bus.m_read, 1'b0);
        chk("rb_state_idle", dut.state_q == ARB_IDLE, 1'b1);
        bus.m_resp = 1'b1; bus.m_rdata = rand_line();
        #1;
        chk("rb_no_dresp", bus.d_resp, 1'b0);
        chk("rb_no_iresp", bus.i_resp, 1'b0);
        chk("rb_no_drdata", bus.d_rdata, '0);
        step();
        bus.m_resp = 1'b0; bus.d_read = 1'b0; rst_n = 1'b1;
        step();
        chk("rb_after_mrd", bus.m_read, 1'b0);

        // d_read held through d_resp, dropped in the dead cycle: one transaction only.
        bus.d_read = 1'b1; bus.d_address = 32'h400;
        step();
        answer("hold", 1'b0, 32'h400, '0, 1'b1, rand_line());
        step();
        bus.m_resp = 1'b0; bus.d_read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_no_regrant", bus.m_read, 1'b0);
            step();
        end

        // Random traffic with a variable-latency memory.
        mem_wait = -1; n_i_served = 0; n_d_served = 0;
        for (int c = 0; c < 3040; c++) begin
            @(negedge clk);
            i_got = bus.i_resp;
            d_got = bus.d_resp;
            if (i_got) n_i_served++;
            if (d_got) n_d_served++;
            step();
            bus.m_resp = 1'b0;
            if (bus.m_read || bus.m_write) begin
                if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
                if (mem_wait == 0) begin
                    bus.m_resp  = 1'b1;
                    bus.m_rdata = rand_line();
                    mem_wait    = -1;
                end else begin
                    mem_wait--;
                end
            end
            if (i_got) begin
                bus.i_read = 1'b0;
            end else if (!bus.i_read && c < 3000 && $urandom_range(0, 2) == 0) begin
                bus.i_read    = 1'b1;
                bus.i_address = $urandom & 32'hFFFF_FFE0;
            end
            if (d_got) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else if (!(bus.d_read || bus.d_write) && c < 3000 &&
                         $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) bus.d_write = 1'b1;
                else                           bus.d_read  = 1'b1;
                bus.d_address = $urandom & 32'hFFFF_FFE0;
                bus.d_wdata   = rand_line();
            end
        end
        chk("rand_i_served", n_i_served > 0, 1'b1);
        chk("rand_d_served", n_d_served > 0, 1'b1);
        chk("rand_drained", bus.i_read || bus.d_read || bus.d_write, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
